// File: rtl/dmem_mmio_if.sv
`timescale 1ns/1ps
// dmem_mmio_if: cpu-to-data-memory bus.
//   memwrite  - write strobe, sampled on the rising clk edge
//   addr      - word address (cpu aluout)
//   writedata - store data
//   readdata  - combinational load data
// master = cpu side, slave = memory side.
interface dmem_mmio_if #(
  parameter int n = 16
);
  logic         memwrite;
  logic [n-1:0] addr;
  logic [n-1:0] writedata;
  logic [n-1:0] readdata;

  modport master (output memwrite, output addr, output writedata, input readdata);
  modport slave  (input memwrite, input addr, input writedata, output readdata);
endinterface

// File: rtl/dmem_mmio.sv
`timescale 1ns/1ps
// dmem_mmio: data-memory stage behind the 16-bit single-cycle cpu.
// Word-addressed RAM at 0 .. 2^AW-1 plus an MMIO page:
//   FFF0 OUT    output register (drives io_out)
//   FFF1 CNT    free-running cycle counter, loadable
//   FFF2 CMP    timer compare value
//   FFF3 STATUS bit0 match flag (W1C, sticky), bit1 timer enable
// Ports:
//   clk, reset - system clock, asynchronous active-high reset
//   bus        - slave side of dmem_mmio_if (memwrite/addr/writedata/readdata)
//   io_out     - OUT register contents
//   irq        - match flag (STATUS[0])
// Unmapped addresses read 0 and ignore writes. RAM is not reset.
module dmem_mmio #(
  parameter int n  = 16,
  parameter int AW = 8
) (
  input  logic         clk,
  input  logic         reset,
  dmem_mmio_if.slave   bus,
  output logic [n-1:0] io_out,
  output logic         irq
);

  localparam logic [n-1:0] ADDR_OUT    = {{(n-4){1'b1}}, 4'h0};
  localparam logic [n-1:0] ADDR_CNT    = {{(n-4){1'b1}}, 4'h1};
  localparam logic [n-1:0] ADDR_CMP    = {{(n-4){1'b1}}, 4'h2};
  localparam logic [n-1:0] ADDR_STATUS = {{(n-4){1'b1}}, 4'h3};

  logic [n-1:0] ram [2**AW];
  logic [n-1:0] out_q;
  logic [n-1:0] cnt_q;
  logic [n-1:0] cmp_q;
  logic         en_q;
  logic         flag_q;

  logic         ram_sel;
  logic         wr_ram;
  logic         wr_out;
  logic         wr_cnt;
  logic         wr_cmp;
  logic         wr_status;
  logic         match;
  logic [n-1:0] rd;

  // Full-width decode: RAM only when every bit above the RAM index is zero.
  assign ram_sel   = (bus.addr[n-1:AW] == '0);
  assign wr_ram    = bus.memwrite && ram_sel;
  assign wr_out    = bus.memwrite && (bus.addr == ADDR_OUT);
  assign wr_cnt    = bus.memwrite && (bus.addr == ADDR_CNT);
  assign wr_cmp    = bus.memwrite && (bus.addr == ADDR_CMP);
  assign wr_status = bus.memwrite && (bus.addr == ADDR_STATUS);

  // Evaluated on pre-edge enable and counter, so a same-edge STATUS or CNT
  // write cannot mask or fake a match.
  assign match = en_q && (cnt_q == cmp_q);

  // RAM has no reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_ram) ram[bus.addr[AW-1:0]] <= bus.writedata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q  <= '0;
      cnt_q  <= '0;
      cmp_q  <= '0;
      en_q   <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      if (wr_out) out_q <= bus.writedata;
      if (wr_cmp) cmp_q <= bus.writedata;
      cnt_q <= wr_cnt ? bus.writedata : cnt_q + 1'b1;
      if (wr_status) en_q <= bus.writedata[1];
      // Set has priority over write-1-to-clear.
      if (match)                              flag_q <= 1'b1;
      else if (wr_status && bus.writedata[0]) flag_q <= 1'b0;
    end
  end

  always_comb begin
    rd = '0;
    if (ram_sel) begin
      rd = ram[bus.addr[AW-1:0]];
    end else begin
      case (bus.addr)
        ADDR_OUT:    rd = out_q;
        ADDR_CNT:    rd = cnt_q;
        ADDR_CMP:    rd = cmp_q;
        ADDR_STATUS: rd = {{(n-2){1'b0}}, en_q, flag_q};
        default:     rd = '0;
      endcase
    end
  end

  assign bus.readdata = rd;
  assign io_out       = out_q;
  assign irq          = flag_q;

endmodule

// File: tb/tb_dmem_mmio.sv
`timescale 1ns/1ps
module tb_dmem_mmio;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] io_out;
  logic        irq;

  dmem_mmio_if #(.n(16)) bus ();

  dmem_mmio #(.n(16), .AW(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .io_out (io_out),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: memory map as plain arrays and variables.
  logic [15:0] m_ram [256];
  bit          m_known [256];
  logic [15:0] m_out, m_cnt, m_cmp;
  bit          m_en, m_flag;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_cnt = 0; m_cmp = 0; m_en = 0; m_flag = 0;
  endtask

  // Returns 1 when the model knows what a read of a should return.
  function automatic bit model_read(input logic [15:0] a, output logic [15:0] v);
    v = 16'h0;
    if (a < 16'd256) begin
      v = m_ram[a[7:0]];
      return m_known[a[7:0]];
    end
    case (a)
      16'hFFF0: v = m_out;
      16'hFFF1: v = m_cnt;
      16'hFFF2: v = m_cmp;
      16'hFFF3: v = {14'h0, m_en, m_flag};
      default:  v = 16'h0;
    endcase
    return 1'b1;
  endfunction

  task automatic model_edge(input bit we, input logic [15:0] a, input logic [15:0] wd);
    bit hit;
    hit = m_en && (m_cnt == m_cmp);
    m_cnt = m_cnt + 16'd1;
    if (we) begin
      if (a < 16'd256) begin
        m_ram[a[7:0]] = wd;
        m_known[a[7:0]] = 1'b1;
      end
      if (a == 16'hFFF0) m_out = wd;
      if (a == 16'hFFF1) m_cnt = wd;
      if (a == 16'hFFF2) m_cmp = wd;
      if (a == 16'hFFF3) begin
        m_en = wd[1];
        if (wd[0]) m_flag = 1'b0;
      end
    end
    if (hit) m_flag = 1'b1;
  endtask

  // One bus cycle; starts between edges, ends 1 ns after the rising edge.
  task automatic tick(input bit we, input logic [15:0] a, input logic [15:0] wd,
                      output logic [15:0] rd_pre);
    logic [15:0] mv;
    bus.memwrite  = we;
    bus.addr      = a;
    bus.writedata = wd;
    #1;
    rd_pre = bus.readdata;
    if (model_read(a, mv)) check("model_read", rd_pre, mv);
    @(posedge clk);
    model_edge(we, a, wd);
    #1;
    check("model_io_out", io_out, m_out);
    check("model_irq", {15'h0, irq}, {15'h0, m_flag});
  endtask

  typedef struct {
    bit          we;
    logic [15:0] a;
    logic [15:0] wd;
    bit          chk;
    logic [15:0] exp;
    string       nm;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit we, input logic [15:0] a, input logic [15:0] wd,
                              input bit chk, input logic [15:0] exp, input string nm);
    vec_t v;
    v.we = we; v.a = a; v.wd = wd; v.chk = chk; v.exp = exp; v.nm = nm;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [15:0] rd;
    int          first;

    add(1, 16'd5,    16'h1234, 0, 16'h0,    "ram_wr5");
    add(1, 16'd255,  16'hBEEF, 0, 16'h0,    "ram_wr255");
    add(0, 16'd5,    16'h0,    1, 16'h1234, "ram_rd5");
    add(0, 16'd255,  16'h0,    1, 16'hBEEF, "ram_rd255");
    add(1, 16'd256,  16'h1111, 0, 16'h0,    "wr256");
    add(0, 16'd256,  16'h0,    1, 16'h0000, "rd256");
    add(1, 16'd5,    16'h5555, 1, 16'h1234, "same_cycle_old");
    add(0, 16'd5,    16'h0,    1, 16'h5555, "same_cycle_new");
    add(1, 16'hFFF0, 16'h00A5, 0, 16'h0,    "out_wr");
    add(0, 16'hFFF0, 16'h0,    1, 16'h00A5, "out_rd");
    add(1, 16'hFFF1, 16'hFFFE, 0, 16'h0,    "cnt_wr");
    add(0, 16'hFFF1, 16'h0,    1, 16'hFFFE, "cnt_fffe");
    add(0, 16'hFFF1, 16'h0,    1, 16'hFFFF, "cnt_ffff");
    add(0, 16'hFFF1, 16'h0,    1, 16'h0000, "cnt_wrap");
    add(1, 16'hFFF1, 16'h0010, 1, 16'h0001, "cnt_load_pre");
    add(0, 16'hFFF1, 16'h0,    1, 16'h0010, "cnt_loaded");
    add(1, 16'hFFF4, 16'hFFFF, 0, 16'h0,    "unmapped_wr");
    add(0, 16'hFFF4, 16'h0,    1, 16'h0000, "unmapped_rd");
    add(0, 16'h7FFF, 16'h0,    1, 16'h0000, "unmapped_rd2");

    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    bus.memwrite = 0; bus.addr = 16'hFFF1; bus.writedata = 0;

    // Asynchronous reset between edges.
    #2 reset = 1'b1;
    #1;
    check("rst_io_out", io_out, 16'h0);
    check("rst_irq", {15'h0, irq}, 16'h0);
    check("rst_cnt", bus.readdata, 16'h0);
    bus.addr = 16'hFFF3;
    #1 check("rst_status", bus.readdata, 16'h0);
    #3 reset = 1'b0;
    model_reset();

    foreach (vecs[i]) begin
      tick(vecs[i].we, vecs[i].a, vecs[i].wd, rd);
      if (vecs[i].chk) check(vecs[i].nm, rd, vecs[i].exp);
    end
    check("io_out_a5", io_out, 16'h00A5);

    // Timer match latency.
    tick(1, 16'hFFF2, 16'h0020, rd);
    tick(1, 16'hFFF1, 16'h0010, rd);
    tick(1, 16'hFFF3, 16'h0002, rd);
    first = 0;
    for (int j = 1; j <= 40; j++) begin
      tick(0, 16'hFFF3, 16'h0, rd);
      if (irq) begin first = j; break; end
    end
    check("irq_latency", 16'(first), 16'd16);

    // W1C keeps enable.
    tick(1, 16'hFFF3, 16'h0003, rd);
    check("w1c_irq", {15'h0, irq}, 16'h0);
    tick(0, 16'hFFF3, 16'h0, rd);
    check("w1c_status", rd, 16'h0002);

    // Clear on the same edge as a match: set wins.
    tick(1, 16'hFFF1, 16'h0020, rd);
    tick(1, 16'hFFF3, 16'h0003, rd);
    check("set_beats_clear", {15'h0, irq}, 16'h1);

    // CNT write on a match edge: match uses old CNT, write still loads.
    tick(1, 16'hFFF3, 16'h0003, rd);
    tick(1, 16'hFFF1, 16'h0020, rd);
    tick(1, 16'hFFF1, 16'h0100, rd);
    check("cnt_wr_match_irq", {15'h0, irq}, 16'h1);
    tick(0, 16'hFFF1, 16'h0, rd);
    check("cnt_wr_match_load", rd, 16'h0100);

    // Enable off: no flag.
    tick(1, 16'hFFF3, 16'h0001, rd);
    tick(1, 16'hFFF1, 16'h0020, rd);
    tick(0, 16'hFFF3, 16'h0, rd);
    check("dis_status", rd, 16'h0000);
    check("dis_irq", {15'h0, irq}, 16'h0);

    // Reset mid-operation.
    tick(1, 16'hFFF0, 16'h00FF, rd);
    tick(1, 16'hFFF3, 16'h0002, rd);
    tick(1, 16'hFFF1, 16'h0020, rd);
    tick(0, 16'hFFF1, 16'h0, rd);
    check("pre_rst_irq", {15'h0, irq}, 16'h1);
    check("pre_rst_out", io_out, 16'h00FF);
    bus.memwrite = 0; bus.addr = 16'hFFF1;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_out", io_out, 16'h0);
    check("mid_rst_irq", {15'h0, irq}, 16'h0);
    check("mid_rst_cnt", bus.readdata, 16'h0);
    bus.addr = 16'hFFF2;
    #1 check("mid_rst_cmp", bus.readdata, 16'h0);
    #1 reset = 1'b0;
    model_reset();
    tick(0, 16'hFFF1, 16'h0, rd); check("post_rst_cnt0", rd, 16'h0000);
    tick(0, 16'hFFF1, 16'h0, rd); check("post_rst_cnt1", rd, 16'h0001);
    tick(0, 16'hFFF1, 16'h0, rd); check("post_rst_cnt2", rd, 16'h0002);
    tick(0, 16'd5,    16'h0, rd); check("ram_retained", rd, 16'h5555);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic [15:0] a, wd;
      int sel;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2: a = 16'($urandom_range(0, 15));
        3:       a = 16'($urandom_range(0, 255));
        4:       a = 16'hFFF0;
        5:       a = 16'hFFF1;
        6:       a = 16'hFFF2;
        7:       a = 16'hFFF3;
        8:       a = 16'($urandom_range(256, 16'hFFEF));
        default: a = 16'($urandom_range(16'hFFF4, 16'hFFFF));
      endcase
      wd = 16'($urandom);
      if (a == 16'hFFF1 && $urandom_range(0, 1) == 0) wd = m_cmp - 16'($urandom_range(0, 3));
      tick(($urandom_range(0, 1) == 1), a, wd, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
